// File: rtl/decseq_pkg.sv
// -----------------------------------------------------------------------------
// decseq_pkg
//   Shared definitions for decoder_sequencer and its bench.
//   - DECSEQ_SEL_W : default width of the binary select / index.
//   - decseq_out_w : one-hot width derived from a select width (1 << sel_w).
//   - decseq_mode_e: behaviour at the last index. Wrap-to-0 by default, or
//                    saturate when the build defines DECSEQ_SATURATE_EN.
//   - DECSEQ_MODE  : the mode this build was compiled with.
// Configuration macro: DECSEQ_SATURATE_EN
// -----------------------------------------------------------------------------
package decseq_pkg;

  localparam int DECSEQ_SEL_W = 3;

  function automatic int decseq_out_w(input int sel_w);
    return 1 << sel_w;
  endfunction

  typedef enum logic {
    DECSEQ_MODE_WRAP = 1'b0,
    DECSEQ_MODE_SAT  = 1'b1
  } decseq_mode_e;

`ifdef DECSEQ_SATURATE_EN
  localparam decseq_mode_e DECSEQ_MODE = DECSEQ_MODE_SAT;
`else
  localparam decseq_mode_e DECSEQ_MODE = DECSEQ_MODE_WRAP;
`endif

endpackage

// File: rtl/onehot_decoder_en.sv
// -----------------------------------------------------------------------------
// onehot_decoder_en
//   Combinational SEL_W -> 2^SEL_W one-hot decoder with an enable.
//   Ports:
//     en_i     in   1      when low the output is all-zero
//     sel_i    in   SEL_W  binary select
//     onehot_o out  OUT_W  one-hot of sel_i, or zero when disabled
// -----------------------------------------------------------------------------
module onehot_decoder_en
  import decseq_pkg::*;
#(
  parameter int SEL_W = DECSEQ_SEL_W,
  localparam int OUT_W = decseq_out_w(SEL_W)
) (
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [OUT_W-1:0] onehot_o
);

  // NOTE: every combinational output is assigned a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_sequencer.sv
// -----------------------------------------------------------------------------
// decoder_sequencer
//   Registered one-hot decoder driven by an internal index register. The index
//   is either loaded from a binary select or auto-stepped, wrapping to 0 after
//   a programmable last index. Used for register-file / memory-bank write
//   selects and multi-cycle scan sequences.
//
//   Ports:
//     Clock           in   1      rising-edge clock
//     Reset_n         in   1      asynchronous active-low reset
//     Enable          in   1      gates the output and Step (Load ignores it)
//     Load            in   1      load index from Decoder_Input (beats Step)
//     Decoder_Input   in   SEL_W  binary value for Load
//     Step            in   1      advance index by one
//     Last_Index      in   SEL_W  final index before wrap, sampled every cycle
//     Decoder_Output  out  OUT_W  one-hot of index, all-zero when disabled
//     Index           out  SEL_W  current index register
//     Wrap            out  1      one-cycle pulse after a Step that wrapped
//
//   Configuration macro: DECSEQ_SATURATE_EN
//     Defined  : a Step at or beyond Last_Index holds the index; Wrap stays 0.
//     Undefined: a Step at or beyond Last_Index returns the index to 0 and
//                pulses Wrap.
// -----------------------------------------------------------------------------
module decoder_sequencer
  import decseq_pkg::*;
#(
  parameter int SEL_W = DECSEQ_SEL_W,
  localparam int OUT_W = decseq_out_w(SEL_W)
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Enable,
  input  logic             Load,
  input  logic [SEL_W-1:0] Decoder_Input,
  input  logic             Step,
  input  logic [SEL_W-1:0] Last_Index,
  output logic [OUT_W-1:0] Decoder_Output,
  output logic [SEL_W-1:0] Index,
  output logic             Wrap
);

  logic [SEL_W-1:0] index_q, index_d;
  logic             en_q,    en_d;
  logic             wrap_q,  wrap_d;
  logic             at_last;

  // The >= compare also catches an index loaded beyond Last_Index, so the
  // increment below can never run past the top of the SEL_W range.
  assign at_last = (index_q >= Last_Index);

  always_comb begin
    index_d = index_q;
    wrap_d  = 1'b0;
    en_d    = Enable;
    if (Load) begin
      index_d = Decoder_Input;
    end else if (Enable && Step) begin
      if (at_last) begin
`ifdef DECSEQ_SATURATE_EN
        index_d = index_q;
`else
        index_d = '0;
        wrap_d  = 1'b1;
`endif
      end else begin
        index_d = index_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of code order.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      index_q <= '0;
      en_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      index_q <= index_d;
      en_q    <= en_d;
      wrap_q  <= wrap_d;
    end
  end

  // Output is decoded from registered state only, so there is no
  // combinational path from any input to Decoder_Output.
  onehot_decoder_en #(
    .SEL_W (SEL_W)
  ) u_onehot (
    .en_i     (en_q),
    .sel_i    (index_q),
    .onehot_o (Decoder_Output)
  );

  assign Index = index_q;
  assign Wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_sequencer.sv
// -----------------------------------------------------------------------------
// tb_decoder_sequencer
//   Self-checking bench for decoder_sequencer. Two instances: SEL_W=3 (main)
//   and SEL_W=4 (16-bit walk). A behavioural model tracks the index as a plain
//   integer and derives the expected one-hot as 1 << index. The expected
//   behaviour at the last index follows decseq_pkg::DECSEQ_MODE.
// -----------------------------------------------------------------------------
module tb_decoder_sequencer;
  import decseq_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset_n;

  // SEL_W = 3 instance
  logic       en3, load3, step3;
  logic [2:0] din3, last3;
  logic [7:0] out3;
  logic [2:0] idx3;
  logic       wrap3;

  // SEL_W = 4 instance
  logic        en4, load4, step4;
  logic [3:0]  din4, last4;
  logic [15:0] out4;
  logic [3:0]  idx4;
  logic        wrap4;

  int checks   = 0;
  int failures = 0;

  // Model state
  int m3_idx, m4_idx;
  bit m3_en, m4_en, m3_wrap, m4_wrap;

  decoder_sequencer #(.SEL_W(3)) dut3 (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .Enable         (en3),
    .Load           (load3),
    .Decoder_Input  (din3),
    .Step           (step3),
    .Last_Index     (last3),
    .Decoder_Output (out3),
    .Index          (idx3),
    .Wrap           (wrap3)
  );

  decoder_sequencer #(.SEL_W(4)) dut4 (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .Enable         (en4),
    .Load           (load4),
    .Decoder_Input  (din4),
    .Step           (step4),
    .Last_Index     (last4),
    .Decoder_Output (out4),
    .Index          (idx4),
    .Wrap           (wrap4)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural rule for one clock edge.
  function automatic void model_next(input int idx, input int last, input int din,
                                     input bit load, input bit en, input bit step,
                                     output int nidx, output bit nwrap);
    nidx  = idx;
    nwrap = 1'b0;
    if (load) begin
      nidx = din;
    end else if (en && step) begin
      if (idx >= last) begin
        if (DECSEQ_MODE == DECSEQ_MODE_WRAP) begin
          nidx  = 0;
          nwrap = 1'b1;
        end
      end else begin
        nidx = idx + 1;
      end
    end
  endfunction

  task automatic model_reset();
    m3_idx = 0; m3_en = 1'b0; m3_wrap = 1'b0;
    m4_idx = 0; m4_en = 1'b0; m4_wrap = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "/idx3"},  32'(idx3),  32'(m3_idx));
    check({tag, "/out3"},  32'(out3),  m3_en ? (32'd1 << m3_idx) : 32'd0);
    check({tag, "/wrap3"}, 32'(wrap3), 32'(m3_wrap));
    check({tag, "/idx4"},  32'(idx4),  32'(m4_idx));
    check({tag, "/out4"},  32'(out4),  m4_en ? (32'd1 << m4_idx) : 32'd0);
    check({tag, "/wrap4"}, 32'(wrap4), 32'(m4_wrap));
  endtask

  // One clock edge: compute model next state from the current inputs, let the
  // edge pass, then compare 1 time unit later.
  task automatic cycle(input string tag);
    int n3, n4;
    bit w3, w4;
    model_next(m3_idx, int'(last3), int'(din3), load3, en3, step3, n3, w3);
    model_next(m4_idx, int'(last4), int'(din4), load4, en4, step4, n4, w4);
    @(posedge Clock);
    #1;
    m3_idx = n3; m3_wrap = w3; m3_en = en3;
    m4_idx = n4; m4_wrap = w4; m4_en = en4;
    check_all(tag);
  endtask

  initial begin
    Reset_n = 1'b0;
    en3 = 1'b0; load3 = 1'b0; step3 = 1'b0; din3 = '0; last3 = 3'd7;
    en4 = 1'b0; load4 = 1'b0; step4 = 1'b0; din4 = '0; last4 = 4'd15;
    model_reset();
    #12;
    check_all("reset");
    @(negedge Clock);
    Reset_n = 1'b1;

    // Reach index 5 with Enable=1, then reset asynchronously between edges.
    en3 = 1'b1; load3 = 1'b1; din3 = 3'd5;
    cycle("load5");
    check("load5/out_const", 32'(out3), 32'h20);
    load3 = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst/out", 32'(out3), 32'h00);
    check("async_rst/idx", 32'(idx3), 32'h0);
    check("async_rst/wrap", 32'(wrap3), 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Load 6, then Load and Step together (Load wins).
    en3 = 1'b1; load3 = 1'b1; din3 = 3'd6;
    cycle("load6");
    check("load6/out_const", 32'(out3), 32'h40);
    step3 = 1'b1; din3 = 3'd2;
    cycle("load_beats_step");
    check("load_beats_step/out_const", 32'(out3), 32'h04);

    // Full walk from 0 with Last_Index = 7, nine steps.
    din3 = 3'd0;
    cycle("load0");
    load3 = 1'b0; last3 = 3'd7;
    for (int i = 0; i < 9; i++) cycle("walk7");

    // Loaded index beyond Last_Index.
    last3 = 3'd2; load3 = 1'b1; din3 = 3'd5; step3 = 1'b0;
    cycle("load_above_last");
    load3 = 1'b0; step3 = 1'b1;
    cycle("step_above_last");

    // Last_Index = 0: index pinned at 0.
    last3 = 3'd0;
    for (int i = 0; i < 3; i++) cycle("last0");

    // Enable low with Step held at index 3, then re-enable.
    load3 = 1'b1; din3 = 3'd3; step3 = 1'b0; last3 = 3'd7;
    cycle("load3");
    load3 = 1'b0; en3 = 1'b0; step3 = 1'b1;
    for (int i = 0; i < 4; i++) cycle("disabled");
    check("disabled/out_const", 32'(out3), 32'h00);
    check("disabled/idx_const", 32'(idx3), 32'h3);
    en3 = 1'b1; step3 = 1'b0;
    cycle("reenable");
    check("reenable/out_const", 32'(out3), 32'h08);

    // Saturation scenario: Last_Index=4, stepping from 3 three times.
    load3 = 1'b1; din3 = 3'd3; last3 = 3'd4;
    cycle("load3_sat");
    load3 = 1'b0; step3 = 1'b1;
    for (int i = 0; i < 3; i++) cycle("step_last4");

    // Last_Index changed mid-sequence takes effect in the same cycle.
    last3 = 3'd7; load3 = 1'b1; din3 = 3'd1;
    cycle("load1");
    load3 = 1'b0;
    cycle("step_to2");
    last3 = 3'd2;
    cycle("last_lowered");

    // 16-bit walk on the SEL_W=4 instance.
    step3 = 1'b0;
    en4 = 1'b1; step4 = 1'b1; last4 = 4'd15;
    for (int i = 0; i < 18; i++) cycle("walk15");

    // Randomized traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      en3   = ($urandom_range(7) != 0);
      load3 = ($urandom_range(7) == 0);
      step3 = ($urandom_range(3) != 0);
      din3  = 3'($urandom);
      last3 = ($urandom_range(3) == 0) ? 3'($urandom) : last3;
      en4   = ($urandom_range(7) != 0);
      load4 = ($urandom_range(7) == 0);
      step4 = ($urandom_range(3) != 0);
      din4  = 4'($urandom);
      last4 = ($urandom_range(3) == 0) ? 4'($urandom) : last4;
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
